// File: rtl/mac_row_array.sv
// Row-vector MAC array: streams DEPTH beats of a scalar A and a B row, accumulating
// LANES dot-product lanes through a three-stage (operand, product, accumulate) pipeline.
module mac_row_array #(
    parameter int unsigned DW    = 16,
    parameter int unsigned LANES = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned ACCW  = 48
) (
    input  logic                     clk,
    input  logic                     MACs_reset,
    input  logic                     start,
    input  logic                     signed_mode,
    input  logic                     sat_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            a_in,
    input  logic [LANES*DW-1:0]      b_in,
    output logic [$clog2(DEPTH)-1:0] k_sel,
    output logic [LANES*ACCW-1:0]    c_out,
    output logic                     c_valid,
    input  logic                     c_ack,
    output logic                     busy,
    output logic [LANES-1:0]         ovf
);

    localparam int unsigned KW = $clog2(DEPTH);
    localparam int unsigned PW = 2 * DW;
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [KW-1:0]               k_sel_q, k_sel_d;
    logic                        sgn_q, sgn_d;
    logic                        sat_q, sat_d;
    logic                        s1_v_q, s1_v_d;
    logic                        s2_v_q, s2_v_d;
    logic [DW-1:0]               a_q, a_d;
    logic [LANES*DW-1:0]         b_q, b_d;
    logic [LANES-1:0][PW-1:0]    prod_q, prod_d;
    logic [LANES-1:0][ACCW-1:0]  acc_q, acc_d;
    logic [LANES-1:0]            ovf_q, ovf_d;
    logic                        in_ready_q, in_ready_d;
    logic                        c_valid_q, c_valid_d;
    logic                        busy_q, busy_d;
    logic                        beat, last_beat, start_go;
    logic [ACCW:0]               lane_sum;

    // Full-width product in the latched number format.
    function automatic logic [PW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic sgn);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = PW'($signed(a));
        sb = PW'($signed(b));
        if (sgn) return sa * sb;
        return PW'(a) * PW'(b);
    endfunction

    // Returns {overflow, next accumulator}; one guard bit exposes the true sum.
    function automatic logic [ACCW:0] acc_add(input logic [ACCW-1:0] acc, input logic [PW-1:0] p,
                                              input logic sgn, input logic sat);
        logic [ACCW:0]   sum;
        logic [ACCW-1:0] r;
        logic            o;
        if (sgn) begin
            sum = (ACCW+1)'($signed(acc)) + (ACCW+1)'($signed(p));
            o   = sum[ACCW] ^ sum[ACCW-1];
        end else begin
            sum = (ACCW+1)'(acc) + (ACCW+1)'(p);
            o   = sum[ACCW];
        end
        r = sum[ACCW-1:0];
        if (sat && o) begin
            if (sgn) r = {sum[ACCW], {(ACCW-1){~sum[ACCW]}}};
            else     r = '1;
        end
        return {o, r};
    endfunction

    // Next-state, pipeline and accumulator logic.
    always_comb begin
        state_d  = state_q;
        k_sel_d  = k_sel_q;
        sgn_d    = sgn_q;
        sat_d    = sat_q;
        s1_v_d   = 1'b0;
        s2_v_d   = s1_v_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        lane_sum = '0;

        beat      = in_valid && (state_q == RUN);
        last_beat = beat && (k_sel_q == K_LAST);
        start_go  = start && ((state_q == IDLE) || ((state_q == DONE) && c_ack));

        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_beat) state_d = DRAIN;
            DRAIN:   if (!s1_v_q && !s2_v_q) state_d = DONE;
            DONE:    if (c_ack) state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (beat) begin
            s1_v_d  = 1'b1;
            a_d     = a_in;
            b_d     = b_in;
            k_sel_d = last_beat ? '0 : k_sel_q + KW'(1);
        end

        if (s1_v_q) begin
            for (int j = 0; j < LANES; j++) begin
                prod_d[j] = mul(a_q, b_q[j*DW +: DW], sgn_q);
            end
        end

        if (start_go) begin
            k_sel_d = '0;
            sgn_d   = signed_mode;
            sat_d   = sat_en;
            acc_d   = '0;
            ovf_d   = '0;
        end else if (s2_v_q) begin
            for (int j = 0; j < LANES; j++) begin
                lane_sum = acc_add(acc_q[j], prod_q[j], sgn_q, sat_q);
                acc_d[j] = lane_sum[ACCW-1:0];
                ovf_d[j] = ovf_q[j] | lane_sum[ACCW];
            end
        end

        in_ready_d = (state_d == RUN);
        c_valid_d  = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge MACs_reset) begin
        if (MACs_reset) begin
            state_q    <= IDLE;
            k_sel_q    <= '0;
            sgn_q      <= 1'b0;
            sat_q      <= 1'b0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= '0;
            in_ready_q <= 1'b0;
            c_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_sel_q    <= k_sel_d;
            sgn_q      <= sgn_d;
            sat_q      <= sat_d;
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            a_q        <= a_d;
            b_q        <= b_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            c_valid_q  <= c_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Result lanes come straight off the accumulators; only meaningful while c_valid.
    assign c_out    = acc_q;
    assign ovf      = ovf_q;
    assign k_sel    = k_sel_q;
    assign in_ready = in_ready_q;
    assign c_valid  = c_valid_q;
    assign busy     = busy_q;

endmodule

// File: doc/mac_row_array.md
MAC_ROW_ARRAY -- requirements
Module: mac_row_array

Interface
REQ-001 Parameter DW, default 16, operand width in bits.
REQ-002 Parameter LANES, default 32, number of parallel MAC lanes (matrix row length).
REQ-003 Parameter DEPTH, default 32, beats accumulated per result row (DEPTH >= 2).
REQ-004 Parameter ACCW, default 48, accumulator width in bits (ACCW >= 2*DW).
REQ-005 Port clk  input  1  clock; all state changes on rising edge.
REQ-006 Port MACs_reset  input  1  reset, asynchronous, active-high.
REQ-007 Port start  input  1  single-cycle request to begin a row.
REQ-008 Port signed_mode  input  1  1 = two's-complement operands; sampled on accepted start.
REQ-009 Port sat_en  input  1  1 = saturating accumulate, 0 = wrapping; sampled on accepted start.
REQ-010 Port in_valid  input  1  a_in/b_in beat valid.
REQ-011 Port in_ready  output  1  block accepts a beat this cycle.
REQ-012 Port a_in  input  DW  scalar element A[row][k].
REQ-013 Port b_in  input  LANES*DW  row B[k]; lane j at bits [j*DW +: DW].
REQ-014 Port k_sel  output  clog2(DEPTH)  index of the beat expected next; drives the upstream A/B select mux.
REQ-015 Port c_out  output  LANES*ACCW  result row; lane j at bits [j*ACCW +: ACCW].
REQ-016 Port c_valid  output  1  c_out is final and stable.
REQ-017 Port c_ack  input  1  consumer has taken c_out.
REQ-018 Port busy  output  1  state is not IDLE.
REQ-019 Port ovf  output  LANES  per-lane sticky overflow flag for the current row.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-021 IDLE: start=1 -> RUN; accumulators, ovf and k_sel cleared; signed_mode and sat_en latched.
REQ-022 start in RUN or DRAIN is ignored, and start in DONE is ignored unless c_ack=1 in the same cycle.
REQ-023 in_ready = 1 only in RUN; a beat is accepted on an edge where in_valid & in_ready.
REQ-024 Accepted beat: operands registered (stage 1), and k_sel increments; k_sel holds when in_valid=0, so bubbles are allowed.
REQ-025 Stage 2 registers LANES full-width 2*DW products, signed or unsigned per the latched mode.
REQ-026 Stage 3 adds the sign- or zero-extended product into the lane accumulator.
REQ-027 The DEPTH-th accepted beat moves RUN -> DRAIN, k_sel wraps to 0, and in_ready drops the same edge.
REQ-028 DRAIN -> DONE once the pipeline is empty; c_valid rises on the third edge after the final beat is accepted.
REQ-029 With in_valid held high, c_valid is asserted DEPTH+3 edges after the edge accepting start.
REQ-030 DONE: c_valid=1, and c_out and ovf are held stable until c_ack.
REQ-031 DONE with c_ack=1 -> IDLE; DONE with c_ack=1 and start=1 -> RUN directly, applying the REQ-021 clears.
REQ-032 c_out is driven directly from the accumulator registers, so outside DONE it shows partial sums and is not valid.
REQ-033 sat_en=0: the sum wraps modulo 2^ACCW.
REQ-034 sat_en=1: the sum clamps to the signed or unsigned ACCW range, per the latched mode.
REQ-035 ovf[j] sets on any stage-3 overflow in lane j in either mode and is cleared only by REQ-021 or reset.
REQ-036 busy = 1 in RUN, DRAIN and DONE.

Reset
REQ-037 MACs_reset=1 immediately forces IDLE and clears k_sel, pipeline valids, accumulators, c_out, ovf and latched modes.
REQ-038 During reset, in_ready, c_valid and busy are 0.
REQ-039 Reset mid-row discards the partial row; no c_valid follows until a new start.
REQ-040 Reset deasserts asynchronously; the first start is honoured on the next edge after deassertion.

Verification
REQ-041 Identity (LANES=4, DEPTH=4, DW=8, ACCW=16, unsigned): a_in=1 every beat, b_in lane j = j+1 -> c_out lanes {4,8,12,16}, c_valid at edge 7 after start, ovf=0.
REQ-042 Bubbles: same stimulus with in_valid low on alternate cycles -> identical c_out; k_sel sequence 0,1,2,3,0 with holds during bubbles.
REQ-043 Signed: a_in=-3 (0xFD), b lane0=5, DEPTH=4 -> lane0 = -60 (0xFFC4), ovf=0.
REQ-044 Saturation (unsigned, sat_en=1): a=255, b=255, DEPTH=4 (raw sum 260100) -> lane = 0xFFFF and ovf set; with sat_en=0 -> 0xF804 and ovf set.
REQ-045 Handshake: c_ack withheld 5 cycles -> c_out stable, start ignored; c_ack together with start -> RUN next edge and accumulators cleared.
REQ-046 Mid-row reset after 2 beats -> all outputs 0 at once; a new full row then produces the correct result.
